// File: rtl/deadlock_mon_pkg.sv
// deadlock_mon_pkg: shared FSM state encoding and counter widths for the AXIS deadlock monitor
package deadlock_mon_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_e;
    localparam int CNT_W = 16;
    localparam int EVT_W = 8;
endpackage

// File: rtl/deadlock_stall_detect.sv
// deadlock_stall_detect: combinational stall term; all-idle means the kernel finished, not stalled
module deadlock_stall_detect #(
    parameter int N_AXIS = 3,
    parameter int N_INST = 2
) (
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              stall
);
    assign stall = (|axis_block_sigs) & (&(inst_idle_sigs | inst_block_sigs)) & ~(&inst_idle_sigs);
endmodule

// File: rtl/axis_deadlock_monitor.sv
// axis_deadlock_monitor: latches a deadlock flag after THRESHOLD consecutive stalled cycles.
// Optional saturating block-event counter enabled by DEADLOCK_MON_EVENT_CNT_EN.
module axis_deadlock_monitor
    import deadlock_mon_pkg::*;
#(
    parameter int N_AXIS    = 3,
    parameter int N_INST    = 2,
    parameter int THRESHOLD = 16
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_rise,
    output logic [N_AXIS-1:0] block_chan,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef DEADLOCK_MON_EVENT_CNT_EN
    ,
    output logic [EVT_W-1:0]  event_cnt
`endif
);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_AXIS-1:0] chan_q;
    logic              block_q, rise_q, stall, hit;

    deadlock_stall_detect #(.N_AXIS(N_AXIS), .N_INST(N_INST)) u_detect (
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .stall          (stall)
    );

    // The first stall out of IDLE counts as 1, so THRESHOLD==1 blocks straight from IDLE.
    assign cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign hit   = stall && (state_q != BLOCKED) && (cnt_d == THR);

    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            block_q <= 1'b0;
            rise_q  <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            block_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= hit;
            if (hit) begin
                state_q <= BLOCKED;
                cnt_q   <= cnt_d;
                chan_q  <= axis_block_sigs;
                block_q <= 1'b1;
            end else if (state_q != BLOCKED) begin
                state_q <= stall ? SUSPECT : IDLE;
                cnt_q   <= stall ? cnt_d : '0;
            end
        end
    end

`ifdef DEADLOCK_MON_EVENT_CNT_EN
    logic [EVT_W-1:0] evt_q;
    // Survives clear so the count spans multiple recoveries.
    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) evt_q <= '0;
        else if (hit && !clear && evt_q != '1) evt_q <= evt_q + EVT_W'(1);
    end
    assign event_cnt = evt_q;
`endif

    assign block      = block_q;
    assign block_rise = rise_q;
    assign block_chan = chan_q;
    assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// tb_axis_deadlock_monitor: directed checks of the deadlock monitor (THRESHOLD=4 and THRESHOLD=1 instances)
module tb_axis_deadlock_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  axis = '0;
    logic [1:0]  idle = '0;
    logic [1:0]  blk = '0;
    logic        clear = 1'b0;
    logic        block, block_rise, block1, block_rise1;
    logic [2:0]  block_chan, block_chan1;
    logic [15:0] stall_cnt, stall_cnt1;
    int          checks = 0;
    int          failures = 0;
    logic        seen;
`ifdef DEADLOCK_MON_EVENT_CNT_EN
    logic [7:0]  event_cnt, event_cnt1;
`endif

    always #5 clk = ~clk;

    axis_deadlock_monitor #(.N_AXIS(3), .N_INST(2), .THRESHOLD(4)) dut (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .axis_block_sigs     (axis),
        .inst_idle_sigs      (idle),
        .inst_block_sigs     (blk),
        .clear               (clear),
        .block               (block),
        .block_rise          (block_rise),
        .block_chan          (block_chan),
        .stall_cnt           (stall_cnt)
`ifdef DEADLOCK_MON_EVENT_CNT_EN
        ,
        .event_cnt           (event_cnt)
`endif
    );

    axis_deadlock_monitor #(.N_AXIS(3), .N_INST(2), .THRESHOLD(1)) dut1 (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .axis_block_sigs     (axis),
        .inst_idle_sigs      (idle),
        .inst_block_sigs     (blk),
        .clear               (clear),
        .block               (block1),
        .block_rise          (block_rise1),
        .block_chan          (block_chan1),
        .stall_cnt           (stall_cnt1)
`ifdef DEADLOCK_MON_EVENT_CNT_EN
        ,
        .event_cnt           (event_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stall_on();
        axis = 3'b010;
        idle = 2'b10;
        blk  = 2'b01;
    endtask

    initial begin
        step();
        chk("rst_block", 32'(block), 0);
        chk("rst_rise", 32'(block_rise), 0);
        chk("rst_chan", 32'(block_chan), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        step();
        chk("idle_cnt", 32'(stall_cnt), 0);

        stall_on();
        step();
        chk("t1_cnt1", 32'(stall_cnt), 1);
        chk("t1_block_early", 32'(block), 0);
        chk("thr1_block", 32'(block1), 1);
        chk("thr1_rise", 32'(block_rise1), 1);
        chk("thr1_chan", 32'(block_chan1), 3'b010);
        step();
        chk("t1_cnt2", 32'(stall_cnt), 2);
        chk("thr1_rise_once", 32'(block_rise1), 0);
        chk("thr1_cnt_sat", 32'(stall_cnt1), 1);
        step();
        chk("t1_cnt3", 32'(stall_cnt), 3);
        chk("t1_block3", 32'(block), 0);
        step();
        chk("t1_cnt4", 32'(stall_cnt), 4);
        chk("t1_block", 32'(block), 1);
        chk("t1_rise", 32'(block_rise), 1);
        chk("t1_chan", 32'(block_chan), 3'b010);
        axis = 3'b000;
        step();
        chk("t1_rise_once", 32'(block_rise), 0);
        chk("t1_sticky", 32'(block), 1);
        chk("t1_cnt_sat", 32'(stall_cnt), 4);
        chk("t1_chan_hold", 32'(block_chan), 3'b010);

        stall_on();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_block", 32'(block), 0);
        chk("clr_cnt", 32'(stall_cnt), 0);
        chk("clr_chan", 32'(block_chan), 0);
        chk("clr_state", 32'(dut.state_q), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("reblk_cnt", 32'(stall_cnt), 32'(i));
            chk("reblk_early", 32'(block), 0);
        end
        step();
        chk("reblk_block", 32'(block), 1);
        chk("reblk_rise", 32'(block_rise), 1);

        clear = 1'b1;
        axis = 3'b000;
        step();
        clear = 1'b0;
        stall_on();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t2_cnt", 32'(stall_cnt), 32'(i));
        end
        axis = 3'b000;
        step();
        chk("t2_gap_cnt", 32'(stall_cnt), 0);
        stall_on();
        step();
        chk("t2_restart_cnt", 32'(stall_cnt), 1);
        chk("t2_no_block", 32'(block), 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        axis = 3'b111;
        idle = 2'b11;
        blk  = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (block || block1 || stall_cnt != 0) seen = 1'b1;
        end
        chk("done_no_stall", 32'(seen), 0);
        chk("done_cnt", 32'(stall_cnt), 0);

        stall_on();
        step();
        step();
        chk("t4_cnt2", 32'(stall_cnt), 2);
        rst = 1'b1;
        #1;
        chk("t4_async_cnt", 32'(stall_cnt), 0);
        chk("t4_async_block", 32'(block), 0);
        chk("t4_async_blk1", 32'(block1), 0);
        chk("t4_async_chan1", 32'(block_chan1), 0);
        #1;
        rst = 1'b0;
        step();
        chk("t4_first_cnt", 32'(stall_cnt), 1);
        chk("t4_block", 32'(block), 0);

`ifdef DEADLOCK_MON_EVENT_CNT_EN
        for (int i = 0; i < 300; i++) begin
            clear = 1'b0;
            step();
            clear = 1'b1;
            step();
        end
        clear = 1'b0;
        chk("evt_sat", 32'(event_cnt1), 255);
        chk("evt_main", 32'(event_cnt), 0);
        rst = 1'b1;
        #1;
        chk("evt_rst", 32'(event_cnt1), 0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
